// File: rtl/fp_align.sv
// fp_align: pre-adder alignment stage for single-precision addition.
// Unpacks both operands, orders them by magnitude and right-shifts the
// smaller mantissa one bit per cycle while collecting a sticky bit.
// Distances beyond MAX_SHIFT, zero distances and Inf/NaN operands skip
// the serial shifter and complete in a single step.
module fp_align #(
  parameter int unsigned MAX_SHIFT = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  exp_max,
  output logic        sign_big,
  output logic        sign_small,
  output logic [23:0] mant_big,
  output logic [23:0] mant_small,
  output logic        sticky,
  output logic        swapped,
  output logic        special
);

  localparam logic [7:0] MAX_SHIFT_W = 8'(MAX_SHIFT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  exp_max_q, exp_max_d;
  logic        sign_big_q, sign_big_d;
  logic        sign_small_q, sign_small_d;
  logic [23:0] mant_big_q, mant_big_d;
  logic [23:0] mant_small_q, mant_small_d;
  logic        sticky_q, sticky_d;
  logic        swapped_q, swapped_d;
  logic        special_q, special_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;

  // Unpacked operand fields and magnitude ordering.
  logic [7:0]  a_eff, b_eff, big_eff, small_eff, diff;
  logic [23:0] a_mant, b_mant, big_mant, small_mant;
  logic        b_larger, is_special;

  // Unpack both operands and pick the larger magnitude (ties go to a).
  always_comb begin
    a_eff      = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
    b_eff      = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
    a_mant     = {(a[30:23] != 8'd0), a[22:0]};
    b_mant     = {(b[30:23] != 8'd0), b[22:0]};
    b_larger   = ({b_eff, b_mant} > {a_eff, a_mant});
    is_special = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
    if (b_larger) begin
      big_eff    = b_eff;
      big_mant   = b_mant;
      small_eff  = a_eff;
      small_mant = a_mant;
    end else begin
      big_eff    = a_eff;
      big_mant   = a_mant;
      small_eff  = b_eff;
      small_mant = b_mant;
    end
    diff = big_eff - small_eff;
  end

  // Next-state, capture and serial-shift datapath.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    exp_max_d    = exp_max_q;
    sign_big_d   = sign_big_q;
    sign_small_d = sign_small_q;
    mant_big_d   = mant_big_q;
    mant_small_d = mant_small_q;
    sticky_d     = sticky_q;
    swapped_d    = swapped_q;
    special_d    = special_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          exp_max_d    = big_eff;
          sign_big_d   = b_larger ? b[31] : a[31];
          sign_small_d = b_larger ? a[31] : b[31];
          mant_big_d   = big_mant;
          mant_small_d = small_mant;
          swapped_d    = b_larger;
          special_d    = is_special;
          sticky_d     = 1'b0;
          cnt_d        = diff;
          if (is_special) begin
            state_d = DONE;
          end else if (diff == 8'd0) begin
            state_d = DONE;
          end else if (diff > MAX_SHIFT_W) begin
            // Everything falls off the end: resolve in one step.
            mant_small_d = 24'd0;
            sticky_d     = |small_mant;
            state_d      = DONE;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        mant_small_d = mant_small_q >> 1;
        sticky_d     = sticky_q | mant_small_q[0];
        cnt_d        = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and output registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      exp_max_q    <= 8'd0;
      sign_big_q   <= 1'b0;
      sign_small_q <= 1'b0;
      mant_big_q   <= 24'd0;
      mant_small_q <= 24'd0;
      sticky_q     <= 1'b0;
      swapped_q    <= 1'b0;
      special_q    <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      exp_max_q    <= exp_max_d;
      sign_big_q   <= sign_big_d;
      sign_small_q <= sign_small_d;
      mant_big_q   <= mant_big_d;
      mant_small_q <= mant_small_d;
      sticky_q     <= sticky_d;
      swapped_q    <= swapped_d;
      special_q    <= special_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign exp_max    = exp_max_q;
  assign sign_big   = sign_big_q;
  assign sign_small = sign_small_q;
  assign mant_big   = mant_big_q;
  assign mant_small = mant_small_q;
  assign sticky     = sticky_q;
  assign swapped    = swapped_q;
  assign special    = special_q;

endmodule
